// File: rtl/hrm_dem_25b.sv
// Harmonic demodulator, 25-bit.
// Takes one (cos, sin) sample pair and recovers its phase (binary angle,
// 2^25 = full turn) and its CORDIC-scaled magnitude by iterative vectoring.
// Also reports the phase step since the previous result.
//
// Handshake: a sample is taken on a rising edge where i_valid and o_ready
// are both high. o_ready is high only while idle, and no sample is queued
// while busy. o_valid pulses for one cycle when o_theta/o_mag/o_delta/
// o_delta_ok change; those outputs then hold until the next pulse.
module hrm_dem_25b #(
   parameter int ITER = 24
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [1:0][24:0] i_val,
   output logic             o_valid,
   output logic [24:0]      o_theta,
   output logic [24:0]      o_mag,
   output logic [24:0]      o_delta,
   output logic             o_delta_ok,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_ROT  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [4:0]  LAST_STEP = 5'(ITER - 1);
   localparam logic [24:0] HALF_TURN = 25'd16777216;

   state_t             r_state;
   logic signed [26:0] r_x;
   logic signed [26:0] r_y;
   logic [24:0]        r_z;
   logic [4:0]         r_i;
   logic               r_zero;
   logic [24:0]        r_prev;
   logic               r_have_prev;

   logic signed [26:0] w_xs;
   logic signed [26:0] w_ys;
   logic signed [26:0] w_x_nxt;
   logic signed [26:0] w_y_nxt;
   logic [24:0]        w_atan;
   logic [24:0]        w_z_nxt;
   logic [24:0]        w_theta_fin;
   logic [24:0]        w_mag_fin;

   // atan(2^-i) as a binary angle, rounded to the nearest LSB of a 2^25 turn.
   function automatic logic [24:0] atan_rom(input logic [4:0] idx);
      logic [24:0] v;
      case (idx)
         5'd0:    v = 25'd4194304;
         5'd1:    v = 25'd2476042;
         5'd2:    v = 25'd1308273;
         5'd3:    v = 25'd664100;
         5'd4:    v = 25'd333339;
         5'd5:    v = 25'd166832;
         5'd6:    v = 25'd83436;
         5'd7:    v = 25'd41721;
         5'd8:    v = 25'd20861;
         5'd9:    v = 25'd10430;
         5'd10:   v = 25'd5215;
         5'd11:   v = 25'd2608;
         5'd12:   v = 25'd1304;
         5'd13:   v = 25'd652;
         5'd14:   v = 25'd326;
         5'd15:   v = 25'd163;
         5'd16:   v = 25'd81;
         5'd17:   v = 25'd41;
         5'd18:   v = 25'd20;
         5'd19:   v = 25'd10;
         5'd20:   v = 25'd5;
         5'd21:   v = 25'd3;
         5'd22:   v = 25'd1;
         5'd23:   v = 25'd1;
         default: v = 25'd0;
      endcase
      return v;
   endfunction

   // One micro-rotation toward y = 0, from the current (pre-step) x, y, z.
   // Also forms the final phase/magnitude so they can be registered on the
   // same edge as the last rotation.
   always_comb begin
      w_xs   = r_x >>> r_i;
      w_ys   = r_y >>> r_i;
      w_atan = atan_rom(r_i);
      if (!r_y[26]) begin
         w_x_nxt = r_x + w_ys;
         w_y_nxt = r_y - w_xs;
         w_z_nxt = r_z + w_atan;
      end else begin
         w_x_nxt = r_x - w_ys;
         w_y_nxt = r_y + w_xs;
         w_z_nxt = r_z - w_atan;
      end
      w_theta_fin = r_zero ? 25'd0 : w_z_nxt;
      // x ends up non-negative; clip anything at or above 2^25
      if (r_zero || w_x_nxt[26]) begin
         w_mag_fin = 25'd0;
      end else if (w_x_nxt[25]) begin
         w_mag_fin = '1;
      end else begin
         w_mag_fin = w_x_nxt[24:0];
      end
   end

   // Control FSM, CORDIC datapath registers and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_i         <= '0;
         r_zero      <= 1'b0;
         r_prev      <= '0;
         r_have_prev <= 1'b0;
         o_ready     <= 1'b1;
         o_valid     <= 1'b0;
         o_theta     <= '0;
         o_mag       <= '0;
         o_delta     <= '0;
         o_delta_ok  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_valid && o_ready) begin
                  r_x     <= {{2{i_val[0][24]}}, i_val[0]};
                  r_y     <= {{2{i_val[1][24]}}, i_val[1]};
                  o_ready <= 1'b0;
                  r_state <= S_PRE;
               end
            end
            S_PRE: begin
               // fold the left half-plane onto the right by a half-turn
               if (r_x[26]) begin
                  r_x <= -r_x;
                  r_y <= -r_y;
                  r_z <= HALF_TURN;
               end else begin
                  r_z <= '0;
               end
               r_zero  <= (r_x == '0) && (r_y == '0);
               r_i     <= '0;
               r_state <= S_ROT;
            end
            S_ROT: begin
               r_x <= w_x_nxt;
               r_y <= w_y_nxt;
               r_z <= w_z_nxt;
               if (r_i == LAST_STEP) begin
                  o_theta     <= w_theta_fin;
                  o_mag       <= w_mag_fin;
                  o_delta     <= r_have_prev ? (w_theta_fin - r_prev) : 25'd0;
                  o_delta_ok  <= r_have_prev;
                  o_valid     <= 1'b1;
                  r_prev      <= w_theta_fin;
                  r_have_prev <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_i <= r_i + 5'd1;
               end
            end
            S_DONE: begin
               o_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               o_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hrm_dem_25b.sv
// Bench for hrm_dem_25b: directed vector table, a streamed rotating phasor
// with i_valid held high, and a reset in the middle of a rotation.
module tb_hrm_dem_25b;

   localparam int ITER   = 24;
   localparam int NS     = 40;
   localparam int STEP   = 1048576;
   localparam int P0     = 33554432 - 5 * 1048576;
   localparam int AMP    = 6291456;
   localparam int BUDGET = NS * (ITER + 3) + 100;

   logic             i_clk;
   logic             i_rst;
   logic             i_valid;
   logic             o_ready;
   logic [1:0][24:0] i_val;
   logic             o_valid;
   logic [24:0]      o_theta;
   logic [24:0]      o_mag;
   logic [24:0]      o_delta;
   logic             o_delta_ok;
   logic [1:0]       o_dbg_state;

   int total;
   int bad;

   logic [24:0] exp_q[$];

   hrm_dem_25b #(.ITER(ITER)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_val       (i_val),
      .o_valid     (o_valid),
      .o_theta     (o_theta),
      .o_mag       (o_mag),
      .o_delta     (o_delta),
      .o_delta_ok  (o_delta_ok),
      .o_dbg_state (o_dbg_state)
   );

   // clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string name, input bit ok, input longint act, input longint exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // modular closeness of two binary angles
   function automatic bit near_ang(input logic [24:0] a, input logic [24:0] e, input int tol);
      logic signed [24:0] d;
      int di;
      d  = a - e;
      di = int'(d);
      return (di <= tol) && (di >= -tol);
   endfunction

   function automatic logic [24:0] phase_of(input int k);
      return 25'(P0 + k * STEP);
   endfunction

   function automatic logic [1:0][24:0] gen(input int k);
      logic [1:0][24:0] v;
      real ph;
      int  c;
      int  s;
      ph   = 2.0 * 3.14159265358979 * real'(phase_of(k)) / 33554432.0;
      c    = int'(real'(AMP) * $cos(ph));
      s    = int'(real'(AMP) * $sin(ph));
      v[0] = 25'(c);
      v[1] = 25'(s);
      return v;
   endfunction

   task automatic reset_dut();
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_val   = '0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   // Send one sample from idle and wait for its result.
   task automatic run_one(input int x, input int y, output logic [24:0] th, output logic [24:0] mg,
                          output logic [24:0] dl, output logic dok, output int lat, output bit tmo);
      int n;
      n   = 0;
      tmo = 1'b0;
      while (!o_ready && n < 100) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      i_val[0] = 25'(x);
      i_val[1] = 25'(y);
      i_valid  = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < ITER + 10) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      tmo = !o_valid;
      th  = o_theta;
      mg  = o_mag;
      dl  = o_delta;
      dok = o_delta_ok;
      lat = n + 1;
   endtask

   typedef struct {
      int          x;
      int          y;
      logic [24:0] th;
      int          th_tol;
      int          mag;
      int          mag_tol;
      logic [24:0] dl;
      bit          dok;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [24:0] th;
      logic [24:0] mg;
      logic [24:0] dl;
      logic        dok;
      int          lat;
      bit          tmo;
      int          acc;
      int          res;
      int          cyc;
      int          last_acc;
      int          nv;
      bit          rdy;
      logic [24:0] e;

      total   = 0;
      bad     = 0;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_val   = '0;

      //        x          y          theta      tol  mag       tol delta      ok
      tbl[0]  = '{4194304,  0,        25'd0,        8, 6907013,  40, 25'd0,        1'b0};
      tbl[1]  = '{0,        4194304,  25'd8388608,  8, 6907013,  40, 25'd8388608,  1'b1};
      tbl[2]  = '{-4194304, 0,        25'd16777216, 8, 6907013,  40, 25'd8388608,  1'b1};
      tbl[3]  = '{0,        -4194304, 25'd25165824, 8, 6907013,  40, 25'd8388608,  1'b1};
      tbl[4]  = '{-8388608, -8388608, 25'd20971520, 8, 19535983, 64, 25'd29360128, 1'b1};
      tbl[5]  = '{0,        0,        25'd0,        0, 0,        0,  25'd12582912, 1'b1};
      tbl[6]  = '{8388608,  8388608,  25'd4194304,  8, 19535983, 64, 25'd4194304,  1'b1};
      tbl[7]  = '{8388608,  -8388608, 25'd29360128, 8, 19535983, 64, 25'd25165824, 1'b1};
      tbl[8]  = '{-8388608, 8388608,  25'd12582912, 8, 19535983, 64, 25'd16777216, 1'b1};
      tbl[9]  = '{8388607,  0,        25'd0,        8, 13814025, 64, 25'd20971520, 1'b1};
      tbl[10] = '{-16777216,-16777216,25'd20971520, 8, 33554431, 0,  25'd20971520, 1'b1};

      // reset state
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_ready", o_ready == 1'b1, o_ready, 1);
      chk("rst_valid", o_valid == 1'b0, o_valid, 0);
      chk("rst_theta", o_theta == 25'd0, o_theta, 0);
      chk("rst_mag", o_mag == 25'd0, o_mag, 0);
      chk("rst_delta", o_delta == 25'd0, o_delta, 0);
      chk("rst_delta_ok", o_delta_ok == 1'b0, o_delta_ok, 0);
      chk("rst_state", o_dbg_state == 2'd0, o_dbg_state, 0);
      i_rst = 1'b0;

      // directed vectors
      for (int k = 0; k < 11; k++) begin
         run_one(tbl[k].x, tbl[k].y, th, mg, dl, dok, lat, tmo);
         chk($sformatf("vec%0d_timeout", k), !tmo, tmo, 0);
         chk($sformatf("vec%0d_latency", k), lat == ITER + 2, lat, ITER + 2);
         chk($sformatf("vec%0d_theta", k), near_ang(th, tbl[k].th, tbl[k].th_tol), th, tbl[k].th);
         chk($sformatf("vec%0d_mag", k),
             (int'(mg) <= tbl[k].mag + tbl[k].mag_tol) && (int'(mg) >= tbl[k].mag - tbl[k].mag_tol),
             mg, tbl[k].mag);
         chk($sformatf("vec%0d_delta_ok", k), dok == tbl[k].dok, dok, tbl[k].dok);
         if (tbl[k].dok)
            chk($sformatf("vec%0d_delta", k), near_ang(dl, tbl[k].dl, 16), dl, tbl[k].dl);
         else
            chk($sformatf("vec%0d_delta", k), dl == 25'd0, dl, 0);
         @(posedge i_clk);
         #1;
         chk($sformatf("vec%0d_pulse", k), o_valid == 1'b0, o_valid, 0);
         chk($sformatf("vec%0d_ready_back", k), o_ready == 1'b1, o_ready, 1);
      end

      // stream of a rotating phasor with i_valid held high
      reset_dut();
      exp_q.delete();
      i_val    = gen(0);
      i_valid  = 1'b1;
      acc      = 0;
      res      = 0;
      cyc      = 0;
      last_acc = 0;
      while ((acc < NS || res < NS) && cyc < BUDGET) begin
         rdy = o_ready;
         @(posedge i_clk);
         #1;
         cyc++;
         if (rdy && i_valid) begin
            if (acc > 0)
               chk("stream_spacing", (cyc - last_acc) == ITER + 3, cyc - last_acc, ITER + 3);
            exp_q.push_back(phase_of(acc));
            last_acc = cyc;
            acc++;
            if (acc < NS) i_val = gen(acc);
            else          i_valid = 1'b0;
         end
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               chk("stream_extra_result", 1'b0, res, NS);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("stream%0d_theta", res), near_ang(o_theta, e, 8), o_theta, e);
               if (res == 0) begin
                  chk("stream0_delta_ok", o_delta_ok == 1'b0, o_delta_ok, 0);
                  chk("stream0_delta", o_delta == 25'd0, o_delta, 0);
               end else begin
                  chk($sformatf("stream%0d_delta_ok", res), o_delta_ok == 1'b1, o_delta_ok, 1);
                  chk($sformatf("stream%0d_delta", res), near_ang(o_delta, 25'(STEP), 8), o_delta, STEP);
               end
            end
            res++;
         end
      end
      i_valid = 1'b0;
      chk("stream_accepts", acc == NS, acc, NS);
      chk("stream_results", res == NS, res, NS);
      chk("stream_queue_empty", exp_q.size() == 0, exp_q.size(), 0);
      nv = 0;
      repeat (ITER + 5) begin
         @(posedge i_clk);
         #1;
         if (o_valid) nv++;
      end
      chk("stream_no_dup", nv == 0, nv, 0);

      // reset during rotation step 10, with a sample offered on the reset edge
      i_val[0] = 25'(4194304);
      i_val[1] = 25'(4194304);
      i_valid  = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (11) @(posedge i_clk);
      #1;
      chk("midrst_in_rot", o_dbg_state == 2'd2, o_dbg_state, 2);
      chk("midrst_busy", o_ready == 1'b0, o_ready, 0);
      i_rst   = 1'b1;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst   = 1'b0;
      i_valid = 1'b0;
      chk("midrst_ready", o_ready == 1'b1, o_ready, 1);
      chk("midrst_valid", o_valid == 1'b0, o_valid, 0);
      chk("midrst_idle", o_dbg_state == 2'd0, o_dbg_state, 0);
      nv = 0;
      repeat (ITER + 5) begin
         @(posedge i_clk);
         #1;
         if (o_valid) nv++;
      end
      chk("midrst_no_valid", nv == 0, nv, 0);
      run_one(0, 4194304, th, mg, dl, dok, lat, tmo);
      chk("midrst_next_timeout", !tmo, tmo, 0);
      chk("midrst_next_theta", near_ang(th, 25'd8388608, 8), th, 8388608);
      chk("midrst_next_delta_ok", dok == 1'b0, dok, 0);
      chk("midrst_next_delta", dl == 25'd0, dl, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
